// File: rtl/wb_pkg.sv
// Shared types and constants for the stream buffer: FSM state, read latency, bank count.
// Read latency depends on the WBUF_REG_OUT_EN macro.
package wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } wb_state_e;

`ifdef WBUF_REG_OUT_EN
    localparam int unsigned RL = 2;
`else
    localparam int unsigned RL = 1;
`endif

    function automatic int unsigned bank_count(input int unsigned addr_w, input int unsigned bank_aw);
        return 32'd1 << (addr_w - bank_aw);
    endfunction

endpackage

// File: rtl/wb_bank_ram.sv
// True dual-port, byte-enabled, read-first RAM bank.
// Read data registers update only on read accesses and hold across writes.
module wb_bank_ram #(
    parameter int unsigned DATA_W = 416,
    parameter int unsigned AW     = 11
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_a_en,
    input  logic                i_a_we,
    input  logic [DATA_W/8-1:0] i_a_be,
    input  logic [AW-1:0]       i_a_addr,
    input  logic [DATA_W-1:0]   i_a_wdata,
    output logic [DATA_W-1:0]   o_a_rdata,
    input  logic                i_b_en,
    input  logic                i_b_we,
    input  logic [DATA_W/8-1:0] i_b_be,
    input  logic [AW-1:0]       i_b_addr,
    input  logic [DATA_W-1:0]   i_b_wdata,
    output logic [DATA_W-1:0]   o_b_rdata
);
    localparam int unsigned NBYTE = DATA_W / 8;
    localparam int unsigned DEPTH = 1 << AW;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] a_mask;
    logic [DATA_W-1:0] b_mask;

    // Expand byte enables to bit masks
    always_comb begin
        a_mask = '0;
        b_mask = '0;
        for (int i = 0; i < NBYTE; i++) begin
            a_mask[i*8 +: 8] = {8{i_a_be[i]}};
            b_mask[i*8 +: 8] = {8{i_b_be[i]}};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_a_en && i_a_we)
            mem[i_a_addr] <= (mem[i_a_addr] & ~a_mask) | (i_a_wdata & a_mask);
        if (i_b_en && i_b_we)
            mem[i_b_addr] <= (mem[i_b_addr] & ~b_mask) | (i_b_wdata & b_mask);
    end

    // Read registers sample the array before this edge's writes land (read-first)
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_a_rdata <= '0;
            o_b_rdata <= '0;
        end else begin
            if (i_a_en && !i_a_we) o_a_rdata <= mem[i_a_addr];
            if (i_b_en && !i_b_we) o_b_rdata <= mem[i_b_addr];
        end
    end

endmodule

// File: rtl/wb_stream_buffer.sv
// Banked word buffer with a host port and a strided read stream feeding a small output FIFO.
// Define WBUF_REG_OUT_EN to register the RAM outputs (read latency 2 instead of 1).
module wb_stream_buffer
    import wb_pkg::*;
#(
    parameter int unsigned DATA_W  = 416,
    parameter int unsigned ADDR_W  = 13,
    parameter int unsigned BANK_AW = 11,
    parameter int unsigned OFIFO_D = 4
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_bc_en,
    input  logic                i_bc_we,
    input  logic [DATA_W/8-1:0] i_bc_be,
    input  logic [ADDR_W-1:0]   i_bc_addr,
    input  logic [DATA_W-1:0]   i_bc_wdata,
    output logic [DATA_W-1:0]   o_bc_rdata,
    input  logic                i_start,
    input  logic [ADDR_W-1:0]   i_start_addr,
    input  logic [ADDR_W:0]     i_len,
    input  logic [ADDR_W-1:0]   i_stride,
    input  logic                i_bypass,
    input  logic                i_abort,
    output logic                o_busy,
    output logic                o_done,
    output logic [DATA_W-1:0]   o_data,
    output logic                o_vld,
    input  logic                i_rdy,
    output logic                o_coll
);
    localparam int unsigned NBANK = bank_count(ADDR_W, BANK_AW);
    localparam int unsigned SEL_W = ADDR_W - BANK_AW;
    localparam int unsigned LEN_W = ADDR_W + 1;
    localparam int unsigned PTR_W = $clog2(OFIFO_D);
    localparam int unsigned CNT_W = PTR_W + 1;

    wb_state_e         state_q, state_d;
    logic              issue_c;
    logic              done_d;
    logic              room_c;
    logic              rd_ram_en;
    logic [LEN_W-1:0]  len_q, issued_q;
    logic [ADDR_W-1:0] addr_q, stride_q;
    logic              bypass_q;
    logic [CNT_W-1:0]  inflight_q;
    logic [CNT_W-1:0]  fifo_cnt;
    logic [CNT_W:0]    occ_c;
    logic [SEL_W-1:0]  h_bank_c, rd_bank_c, h_sel, s1_sel;
    logic              s1_vld, s1_byp;
    logic [DATA_W-1:0] s1_data_c;
    logic              push_vld, push_c, pop_c;
    logic [DATA_W-1:0] push_data;
    logic [PTR_W:0]    wr_ptr, rd_ptr;
    logic [DATA_W-1:0] fifo_mem [OFIFO_D];
    logic [DATA_W-1:0] a_rdata [NBANK];
    logic [DATA_W-1:0] b_rdata [NBANK];

    assign h_bank_c  = i_bc_addr[ADDR_W-1:BANK_AW];
    assign rd_bank_c = addr_q[ADDR_W-1:BANK_AW];
    assign fifo_cnt  = wr_ptr - rd_ptr;
    assign occ_c     = {1'b0, fifo_cnt} + {1'b0, inflight_q};
    assign room_c    = occ_c < (CNT_W+1)'(OFIFO_D);
    assign rd_ram_en = issue_c && !bypass_q;

    // Next-state and issue decision
    always_comb begin
        state_d = state_q;
        issue_c = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start && !i_abort) begin
                    if (i_len == '0) done_d = 1'b1;
                    else             state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (i_abort)                  state_d = ST_IDLE;
                else if (issued_q == len_q)   state_d = ST_DRAIN;
                else if (room_c)              issue_c = 1'b1;
            end
            ST_DRAIN: begin
                if (i_abort) begin
                    state_d = ST_IDLE;
                end else if (inflight_q == '0 && fifo_cnt == '0 && !o_vld) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
        end else begin
            state_q <= state_d;
            o_busy  <= (state_d != ST_IDLE);
            o_done  <= done_d;
        end
    end

    // Stream parameters latched on an accepted start; address wraps naturally
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            addr_q   <= '0;
            len_q    <= '0;
            stride_q <= '0;
            bypass_q <= 1'b0;
            issued_q <= '0;
        end else if (state_q == ST_IDLE && i_start && !i_abort) begin
            addr_q   <= i_start_addr;
            len_q    <= i_len;
            stride_q <= i_stride;
            bypass_q <= i_bypass;
            issued_q <= '0;
        end else if (issue_c) begin
            addr_q   <= addr_q + stride_q;
            issued_q <= issued_q + LEN_W'(1);
        end
    end

    for (genvar b = 0; b < NBANK; b++) begin : g_bank
        wb_bank_ram #(
            .DATA_W (DATA_W),
            .AW     (BANK_AW)
        ) u_ram (
            .i_clk     (i_clk),
            .i_rst_n   (i_rst_n),
            .i_a_en    (i_bc_en && (h_bank_c == SEL_W'(b))),
            .i_a_we    (i_bc_we),
            .i_a_be    (i_bc_be),
            .i_a_addr  (i_bc_addr[BANK_AW-1:0]),
            .i_a_wdata (i_bc_wdata),
            .o_a_rdata (a_rdata[b]),
            .i_b_en    (rd_ram_en && (rd_bank_c == SEL_W'(b))),
            .i_b_we    (1'b0),
            .i_b_be    ('0),
            .i_b_addr  (addr_q[BANK_AW-1:0]),
            .i_b_wdata ('0),
            .o_b_rdata (b_rdata[b])
        );
    end

    // First stage after issue: which bank answered, or a zero word in bypass
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_vld <= 1'b0;
            s1_byp <= 1'b0;
            s1_sel <= '0;
            h_sel  <= '0;
            o_coll <= 1'b0;
        end else begin
            s1_vld <= issue_c && !i_abort;
            if (issue_c) begin
                s1_byp <= bypass_q;
                s1_sel <= rd_bank_c;
            end
            if (i_bc_en && !i_bc_we) h_sel <= h_bank_c;
            o_coll <= i_bc_en && i_bc_we && rd_ram_en && (i_bc_addr == addr_q);
        end
    end

    assign s1_data_c = s1_byp ? '0 : b_rdata[s1_sel];

`ifdef WBUF_REG_OUT_EN
    logic              s2_vld;
    logic [DATA_W-1:0] s2_data;
    logic              h_rd1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s2_vld     <= 1'b0;
            s2_data    <= '0;
            h_rd1      <= 1'b0;
            o_bc_rdata <= '0;
        end else begin
            s2_vld  <= s1_vld && !i_abort;
            s2_data <= s1_data_c;
            h_rd1   <= i_bc_en && !i_bc_we;
            if (h_rd1) o_bc_rdata <= a_rdata[h_sel];
        end
    end

    assign push_vld  = s2_vld;
    assign push_data = s2_data;
`else
    assign push_vld   = s1_vld;
    assign push_data  = s1_data_c;
    assign o_bc_rdata = a_rdata[h_sel];
`endif

    assign push_c = push_vld && !i_abort;
    assign pop_c  = (fifo_cnt != '0) && (!o_vld || i_rdy);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)      inflight_q <= '0;
        else if (i_abort)  inflight_q <= '0;
        else               inflight_q <= inflight_q + CNT_W'(issue_c) - CNT_W'(push_vld);
    end

    always_ff @(posedge i_clk) begin
        if (push_c) fifo_mem[wr_ptr[PTR_W-1:0]] <= push_data;
    end

    // FIFO pointers and the output register that presents the head beat
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            o_vld  <= 1'b0;
            o_data <= '0;
        end else if (i_abort) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            o_vld  <= 1'b0;
        end else begin
            if (push_c) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            if (pop_c) begin
                rd_ptr <= rd_ptr + (PTR_W+1)'(1);
                o_data <= fifo_mem[rd_ptr[PTR_W-1:0]];
                o_vld  <= 1'b1;
            end else if (i_rdy) begin
                o_vld  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wb_stream_buffer.sv
// Directed bench for wb_stream_buffer: host-port vector table plus stream, bypass,
// collision, abort and reset sequences.
module tb_wb_stream_buffer;
    import wb_pkg::*;

    localparam int unsigned DATA_W  = 416;
    localparam int unsigned ADDR_W  = 13;
    localparam int unsigned OFIFO_D = 4;
    localparam int unsigned BE_W    = DATA_W / 8;

    logic                i_clk;
    logic                i_rst_n;
    logic                i_bc_en, i_bc_we;
    logic [BE_W-1:0]     i_bc_be;
    logic [ADDR_W-1:0]   i_bc_addr;
    logic [DATA_W-1:0]   i_bc_wdata;
    logic [DATA_W-1:0]   o_bc_rdata;
    logic                i_start;
    logic [ADDR_W-1:0]   i_start_addr;
    logic [ADDR_W:0]     i_len;
    logic [ADDR_W-1:0]   i_stride;
    logic                i_bypass, i_abort;
    logic                o_busy, o_done, o_vld, o_coll;
    logic [DATA_W-1:0]   o_data;
    logic                i_rdy = 1'b1;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int max_occ = 0;
    int rdy_mode = 0;
    int rdy_cyc = 0;
    bit saw_ram_en = 1'b0;
    bit stall_prev = 1'b0;
    logic [DATA_W-1:0] stall_data;
    logic [DATA_W-1:0] beats[$];
    logic [DATA_W-1:0] expq[$];

    wb_stream_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BANK_AW(11), .OFIFO_D(OFIFO_D)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_bc_en(i_bc_en), .i_bc_we(i_bc_we), .i_bc_be(i_bc_be), .i_bc_addr(i_bc_addr),
        .i_bc_wdata(i_bc_wdata), .o_bc_rdata(o_bc_rdata),
        .i_start(i_start), .i_start_addr(i_start_addr), .i_len(i_len), .i_stride(i_stride),
        .i_bypass(i_bypass), .i_abort(i_abort), .o_busy(o_busy), .o_done(o_done),
        .o_data(o_data), .o_vld(o_vld), .i_rdy(i_rdy), .o_coll(o_coll)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Consumer ready: always high, or random with a 20-cycle low window
    always @(posedge i_clk) begin
        #1;
        if (rdy_mode == 0) begin
            i_rdy = 1'b1;
        end else begin
            rdy_cyc = rdy_cyc + 1;
            i_rdy = (rdy_cyc >= 8 && rdy_cyc < 28) ? 1'b0 : 1'($urandom_range(0, 1));
        end
    end

    // Beat collector, stall-hold checker, occupancy and bypass observers
    always @(negedge i_clk) begin
        if (stall_prev && i_rst_n && !i_abort) begin
            checks++;
            if (!o_vld || o_data !== stall_data) begin
                errors++;
                $display("FAIL stall_hold: vld=%0b data=%0h required vld=1 data=%0h", o_vld, o_data, stall_data);
            end
        end
        stall_prev = o_vld && !i_rdy && i_rst_n && !i_abort;
        stall_data = o_data;
        if (o_vld && i_rdy && !i_abort) beats.push_back(o_data);
        if (o_done) done_cnt++;
        if (int'(dut.fifo_cnt) > max_occ) max_occ = int'(dut.fifo_cnt);
        if (dut.rd_ram_en) saw_ram_en = 1'b1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [DATA_W-1:0] rep(input logic [31:0] w);
        return {(DATA_W/32){w}};
    endfunction

    function automatic logic [BE_W-1:0] rep_be(input logic [3:0] b);
        return {(DATA_W/32){b}};
    endfunction

    function automatic logic [31:0] pat(input int unsigned a);
        return 32'hC0DE_0000 ^ 32'(a);
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic host_write(input logic [ADDR_W-1:0] a, input logic [BE_W-1:0] be, input logic [DATA_W-1:0] d);
        i_bc_en = 1'b1; i_bc_we = 1'b1; i_bc_addr = a; i_bc_be = be; i_bc_wdata = d;
        tick();
        i_bc_en = 1'b0; i_bc_we = 1'b0; i_bc_be = '0;
    endtask

    task automatic host_read(input logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] d);
        i_bc_en = 1'b1; i_bc_we = 1'b0; i_bc_addr = a;
        tick();
        i_bc_en = 1'b0;
        repeat (RL - 1) tick();
        d = o_bc_rdata;
    endtask

    // Start a stream, optionally poke a second start while busy, then compare against expq
    task automatic run_stream(input string name, input logic [ADDR_W-1:0] sa, input logic [ADDR_W:0] len,
                              input logic [ADDR_W-1:0] st, input logic byp, input int poke);
        int d0;
        beats.delete();
        d0 = done_cnt;
        i_start_addr = sa; i_len = len; i_stride = st; i_bypass = byp; i_start = 1'b1;
        tick();
        i_start = 1'b0;
        for (int c = 0; c < 3000 && done_cnt == d0; c++) begin
            if (c == poke) begin
                i_start = 1'b1; i_start_addr = '0; i_len = 3; i_bypass = 1'b0;
            end
            tick();
            i_start = 1'b0;
        end
        check({name, "_done"}, DATA_W'(done_cnt - d0), DATA_W'(1));
        check({name, "_count"}, DATA_W'(beats.size()), DATA_W'(expq.size()));
        for (int i = 0; i < expq.size() && i < beats.size(); i++)
            check($sformatf("%s_beat%0d", name, i), beats[i], expq[i]);
    endtask

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [3:0]        be;
        logic [31:0]       wd;
        logic [31:0]       exp;
    } vec_t;

    vec_t vt [12];
    logic [DATA_W-1:0] rd;
    int d0;

    initial begin
        vt[0]  = '{1'b1, 13'h0005, 4'hF, 32'h1111_1111, 32'h0};
        vt[1]  = '{1'b0, 13'h0005, 4'h0, 32'h0,         32'h1111_1111};
        vt[2]  = '{1'b1, 13'h0005, 4'h1, 32'h2222_2222, 32'h0};
        vt[3]  = '{1'b0, 13'h0005, 4'h0, 32'h0,         32'h1111_1122};
        vt[4]  = '{1'b1, 13'h0005, 4'hA, 32'h3333_3333, 32'h0};
        vt[5]  = '{1'b0, 13'h0005, 4'h0, 32'h0,         32'h3311_3322};
        vt[6]  = '{1'b1, 13'h0805, 4'hF, 32'h4444_4444, 32'h0};
        vt[7]  = '{1'b0, 13'h0805, 4'h0, 32'h0,         32'h4444_4444};
        vt[8]  = '{1'b0, 13'h0005, 4'h0, 32'h0,         32'h3311_3322};
        vt[9]  = '{1'b1, 13'h1FFF, 4'hF, 32'h5555_5555, 32'h0};
        vt[10] = '{1'b1, 13'h1FFF, 4'h0, 32'h6666_6666, 32'h0};
        vt[11] = '{1'b0, 13'h1FFF, 4'h0, 32'h0,         32'h5555_5555};

        i_rst_n = 1'b0;
        i_bc_en = 1'b0; i_bc_we = 1'b0; i_bc_be = '0; i_bc_addr = '0; i_bc_wdata = '0;
        i_start = 1'b0; i_start_addr = '0; i_len = '0; i_stride = '0; i_bypass = 1'b0; i_abort = 1'b0;
        #12;
        check("rst_vld",    DATA_W'(o_vld),  '0);
        check("rst_done",   DATA_W'(o_done), '0);
        check("rst_busy",   DATA_W'(o_busy), '0);
        check("rst_coll",   DATA_W'(o_coll), '0);
        check("rst_data",   o_data,          '0);
        check("rst_rdata",  o_bc_rdata,      '0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        tick();

        // Host port vectors
        for (int i = 0; i < 12; i++) begin
            if (vt[i].we) begin
                host_write(vt[i].addr, rep_be(vt[i].be), rep(vt[i].wd));
            end else begin
                host_read(vt[i].addr, rd);
                check($sformatf("host_vec%0d", i), rd, rep(vt[i].exp));
            end
        end
        host_write(13'h0005, rep_be(4'hF), rep(32'h0));
        tick();
        check("rdata_hold", o_bc_rdata, rep(32'h5555_5555));

        // Zero-length start
        i_start = 1'b1; i_len = '0; i_start_addr = 13'h0100;
        tick();
        i_start = 1'b0;
        check("len0_done", DATA_W'(o_done), DATA_W'(1));
        check("len0_busy", DATA_W'(o_busy), '0);
        tick();
        check("len0_pulse", DATA_W'(o_done), '0);

        // Linear stream of 8 words
        expq.delete();
        for (int i = 0; i < 8; i++) begin
            host_write(13'(32'h100 + i), rep_be(4'hF), rep(pat(32'h100 + i)));
            expq.push_back(rep(pat(32'h100 + i)));
        end
        run_stream("lin8", 13'h0100, 14'd8, 13'd1, 1'b0, -1);

        // Wrap across the top of the address space, with an ignored start while busy
        expq.delete();
        for (int i = 0; i < 4; i++) begin
            host_write(13'(32'h1FFE + i), rep_be(4'hF), rep(pat((32'h1FFE + i) & 32'h1FFF)));
            expq.push_back(rep(pat((32'h1FFE + i) & 32'h1FFF)));
        end
        run_stream("wrap", 13'h1FFE, 14'd4, 13'd1, 1'b0, 2);
        check("wrap_idle", DATA_W'(o_busy), '0);

        // Back-pressure with stride 3
        expq.delete();
        for (int i = 0; i < 16; i++) begin
            host_write(13'(32'h200 + 3*i), rep_be(4'hF), rep(pat(32'h200 + 3*i)));
            expq.push_back(rep(pat(32'h200 + 3*i)));
        end
        max_occ = 0;
        rdy_cyc = 0;
        rdy_mode = 1;
        run_stream("bp16", 13'h0200, 14'd16, 13'd3, 1'b0, -1);
        rdy_mode = 0;
        tick();
        check("bp16_occ", DATA_W'(max_occ <= OFIFO_D), DATA_W'(1));

        // Bypass: zero beats, no RAM reads
        expq.delete();
        for (int i = 0; i < 5; i++) expq.push_back('0);
        saw_ram_en = 1'b0;
        run_stream("byp5", 13'h0100, 14'd5, 13'd1, 1'b1, -1);
        check("byp5_noram", DATA_W'(saw_ram_en), '0);

        // Same-cycle host write and stream read
        host_write(13'h0020, rep_be(4'hF), rep(32'h7777_7777));
        beats.delete();
        d0 = done_cnt;
        i_start_addr = 13'h0020; i_len = 14'd1; i_stride = 13'd1; i_bypass = 1'b0; i_start = 1'b1;
        tick();
        i_start = 1'b0;
        i_bc_en = 1'b1; i_bc_we = 1'b1; i_bc_addr = 13'h0020; i_bc_be = rep_be(4'h1); i_bc_wdata = rep(32'h9999_9999);
        tick();
        i_bc_en = 1'b0; i_bc_we = 1'b0; i_bc_be = '0;
        check("coll_pulse", DATA_W'(o_coll), DATA_W'(1));
        tick();
        check("coll_clear", DATA_W'(o_coll), '0);
        for (int c = 0; c < 100 && done_cnt == d0; c++) tick();
        check("coll_done", DATA_W'(done_cnt - d0), DATA_W'(1));
        check("coll_count", DATA_W'(beats.size()), DATA_W'(1));
        if (beats.size() > 0) check("coll_old", beats[0], rep(32'h7777_7777));
        host_read(13'h0020, rd);
        check("coll_after", rd, rep(32'h7777_7799));

        // Abort after 3 beats
        for (int i = 0; i < 10; i++)
            host_write(13'(32'h300 + i), rep_be(4'hF), rep(pat(32'h300 + i)));
        beats.delete();
        d0 = done_cnt;
        i_start_addr = 13'h0300; i_len = 14'd10; i_stride = 13'd1; i_bypass = 1'b0; i_start = 1'b1;
        tick();
        i_start = 1'b0;
        for (int c = 0; c < 200 && beats.size() < 3; c++) tick();
        check("abort_reached3", DATA_W'(beats.size()), DATA_W'(3));
        i_abort = 1'b1; i_start = 1'b1;
        tick();
        i_abort = 1'b0; i_start = 1'b0;
        repeat (RL) tick();
        check("abort_busy", DATA_W'(o_busy), '0);
        check("abort_vld", DATA_W'(o_vld), '0);
        repeat (12) tick();
        check("abort_beats", DATA_W'(beats.size()), DATA_W'(3));
        check("abort_nodone", DATA_W'(done_cnt - d0), '0);
        check("abort_still_idle", DATA_W'(o_busy), '0);
        for (int i = 0; i < 3 && i < beats.size(); i++)
            check($sformatf("abort_beat%0d", i), beats[i], rep(pat(32'h300 + i)));

        // Reset in the middle of a stream
        d0 = done_cnt;
        i_start_addr = 13'h0300; i_len = 14'd10; i_stride = 13'd1; i_start = 1'b1;
        tick();
        i_start = 1'b0;
        repeat (4) tick();
        i_rst_n = 1'b0;
        #2;
        check("mrst_vld",   DATA_W'(o_vld),  '0);
        check("mrst_done",  DATA_W'(o_done), '0);
        check("mrst_busy",  DATA_W'(o_busy), '0);
        check("mrst_coll",  DATA_W'(o_coll), '0);
        check("mrst_data",  o_data,          '0);
        check("mrst_rdata", o_bc_rdata,      '0);
        tick();
        i_rst_n = 1'b1;
        beats.delete();
        repeat (10) tick();
        check("mrst_idle",   DATA_W'(o_busy), '0);
        check("mrst_nobeat", DATA_W'(beats.size()), '0);
        check("mrst_nodone", DATA_W'(done_cnt - d0), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
